// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on a start request, gates one camera frame of
// line-valid into the pixel datapath, checks the frame geometry and buffers
// the assembled pixels in a small FIFO read through a valid/ready port.
// Optional build macro FRAME_CAP_DECIMATE_EN: keep only even-column pixels
// on even rows (half-resolution output); geometry checks still use full counts.
module frame_capture_ctrl #(
  parameter int PixelBitWidth = 16,
  parameter int FrameWidth    = 640,
  parameter int FrameHeight   = 480,
  parameter int FifoDepth     = 8
) (
  input  logic                     p_clk,
  input  logic                     RST,
  input  logic                     v_sync,
  input  logic                     h_sync,
  input  logic                     start,
  input  logic                     abort,
  output logic                     cap_h_sync,
  output logic                     cap_rst_n,
  input  logic [PixelBitWidth-1:0] pix_data,
  input  logic                     pix_ready,
  output logic [PixelBitWidth-1:0] o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int ColW  = $clog2(FrameWidth + 1);
  localparam int RowW  = $clog2(FrameHeight + 1);
  localparam int AddrW = $clog2(FifoDepth);

  localparam logic [ColW-1:0] ColFull = ColW'(FrameWidth);
  localparam logic [ColW-1:0] ColMax  = '1;
  localparam logic [RowW-1:0] RowLast = RowW'(FrameHeight - 1);
`ifdef FRAME_CAP_DECIMATE_EN
  localparam logic [ColW-1:0] ColLastKept = ColW'(FrameWidth - 2);
  localparam logic [RowW-1:0] RowLastKept = RowW'(FrameHeight - 2);
`else
  localparam logic [ColW-1:0] ColLastKept = ColW'(FrameWidth - 1);
  localparam logic [RowW-1:0] RowLastKept = RowW'(FrameHeight - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_SYNC, ST_CAPTURE, ST_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic v_q, h_q;
  logic v_fall, v_rise, h_fall;
  logic capture_en;
  logic start_acc, fifo_flush;
  logic final_line_end;

  logic [ColW-1:0] col_reg;
  logic [RowW-1:0] row_reg;
  logic            overflow_reg, frame_err_reg;

  logic [AddrW:0]           wr_ptr_reg, rd_ptr_reg;
  logic [PixelBitWidth:0]   mem [FifoDepth];
  logic [PixelBitWidth:0]   head;
  logic                     fifo_empty, fifo_full;
  logic                     push_req, push_ok, push_keep, push_last, pop;

  assign v_fall = v_q & ~v_sync;
  assign v_rise = ~v_q & v_sync;
  assign h_fall = h_q & ~h_sync;

  assign start_acc      = (state_reg == ST_IDLE) & start & ~abort;
  assign fifo_flush     = abort | start_acc;
  assign final_line_end = h_fall & (row_reg == RowLast);

  // Raw sync inputs sampled once for edge detection.
  always_ff @(posedge p_clk or posedge RST) begin
    if (RST) begin
      v_q <= 1'b0;
      h_q <= 1'b0;
    end else begin
      v_q <= v_sync;
      h_q <= h_sync;
    end
  end

  // State register.
  always_ff @(posedge p_clk or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_ARM;
      ST_ARM:     if (v_sync) state_next = ST_SYNC;
      ST_SYNC:    if (v_fall) state_next = ST_CAPTURE;
      ST_CAPTURE: if (final_line_end || v_rise) state_next = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Outputs decoded from the state; capture_en is exactly "in CAPTURE".
  always_comb begin
    capture_en = (state_reg == ST_CAPTURE);
    busy       = (state_reg != ST_IDLE);
    cap_h_sync = h_sync & capture_en;
    cap_rst_n  = capture_en;
    done       = (state_reg == ST_DRAIN) & fifo_empty & ~abort;
  end

  // Pixel/line counters; col saturates so an overlong line cannot alias.
  always_ff @(posedge p_clk or posedge RST) begin
    if (RST) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (start_acc) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (capture_en) begin
      if (h_fall) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else if (pix_ready && col_reg != ColMax) begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by an accepted start.
  always_ff @(posedge p_clk or posedge RST) begin
    if (RST) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (start_acc) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (capture_en && !abort) begin
      if (push_req && fifo_full && !pop) overflow_reg <= 1'b1;
      if (h_fall && col_reg != ColFull) frame_err_reg <= 1'b1;
      // A completed final line wins over a simultaneous vsync rise.
      if (v_rise && !final_line_end) frame_err_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

`ifdef FRAME_CAP_DECIMATE_EN
  assign push_keep = ~col_reg[0] & ~row_reg[0];
`else
  assign push_keep = 1'b1;
`endif
  assign push_last = (row_reg == RowLastKept) & (col_reg == ColLastKept);

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]) &&
                      (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]);
  assign pop        = ~fifo_empty & i_ready;
  assign push_req   = capture_en & pix_ready & push_keep;
  assign push_ok    = push_req & (~fifo_full | pop);

  // FIFO pointers; a flush simply realigns them.
  always_ff @(posedge p_clk or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (fifo_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // FIFO storage: {last, pixel} per entry, no reset needed.
  always_ff @(posedge p_clk) begin
    if (push_ok) mem[wr_ptr_reg[AddrW-1:0]] <= {push_last, pix_data};
  end

  assign head    = mem[rd_ptr_reg[AddrW-1:0]];
  assign o_valid = ~fifo_empty;
  // Head is masked while empty so the port reads zero out of reset.
  assign o_data  = o_valid ? head[PixelBitWidth-1:0] : '0;
  assign o_last  = o_valid & head[PixelBitWidth];

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 4x3 frame and 8-entry FIFO.
module tb_frame_capture_ctrl;

  localparam int PW = 16;

  logic          p_clk = 1'b0;
  logic          RST;
  logic          v_sync, h_sync, start, abort;
  logic          cap_h_sync, cap_rst_n;
  logic [PW-1:0] pix_data;
  logic          pix_ready;
  logic [PW-1:0] o_data;
  logic          o_last, o_valid;
  logic          i_ready;
  logic          busy, done, overflow, frame_err;

  frame_capture_ctrl #(
    .PixelBitWidth(PW), .FrameWidth(4), .FrameHeight(3), .FifoDepth(8)
  ) dut (
    .p_clk(p_clk), .RST(RST), .v_sync(v_sync), .h_sync(h_sync),
    .start(start), .abort(abort), .cap_h_sync(cap_h_sync), .cap_rst_n(cap_rst_n),
    .pix_data(pix_data), .pix_ready(pix_ready), .o_data(o_data), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready), .busy(busy), .done(done),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int next_pix = 1;
  logic [PW:0] got_q[$];

  // Scoreboard: record every pop and every done pulse.
  always @(negedge p_clk) begin
    if (o_valid && i_ready) begin
      got_q.push_back({o_last, o_data});
      $display("pop   data=0x%04h last=%0b", o_data, o_last);
    end
    if (done) done_cnt++;
  end

  typedef struct {
    int len0, len1, len2;
    int nlines;
    bit early;
    bit hold;
    int exp_pops;
    int exp_last;
    bit exp_ferr;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic vsync_pulse();
    v_sync = 1'b1;
    tick(); tick(); tick();
    v_sync = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic drive_line(input int n);
    h_sync = 1'b1;
    for (int k = 0; k < n; k++) begin
      pix_ready = 1'b1;
      pix_data  = PW'(next_pix);
      next_pix++;
      tick();
    end
    pix_ready = 1'b0;
    h_sync    = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge p_clk);
      if (done_cnt > 0) break;
    end
    if (done_cnt == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse expected one");
    end
    repeat (5) @(negedge p_clk);
  endtask

  task automatic check_pops(input string tag, input int exp_pops, input int exp_last);
    check({tag, "_pop_count"}, got_q.size(), exp_pops);
    for (int i = 0; i < exp_pops && i < got_q.size(); i++) begin
      check({tag, "_pop_data"}, got_q[i][PW-1:0], i + 1);
      check({tag, "_pop_last"}, got_q[i][PW], (i + 1 == exp_last) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    got_q.delete();
    done_cnt = 0;
    next_pix = 1;
    i_ready  = v.hold ? 1'b0 : 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge p_clk);
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_ferr_cleared"}, frame_err, 0);
    check({tag, "_ovf_cleared"}, overflow, 0);
    vsync_pulse();
    check({tag, "_cap_rst_n_high"}, cap_rst_n, 1);
    if (v.nlines > 0) drive_line(v.len0);
    if (v.nlines > 1) drive_line(v.len1);
    if (v.nlines > 2) drive_line(v.len2);
    if (v.early) begin
      v_sync = 1'b1;
      tick(); tick();
      v_sync = 1'b0;
    end
    if (v.hold) begin
      repeat (4) tick();
      @(negedge p_clk);
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_head"}, o_data, 1);
      check({tag, "_hold_no_done"}, done_cnt, 0);
      i_ready = 1'b1;
    end
    wait_done();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_frame_err"}, frame_err, v.exp_ferr);
    check({tag, "_overflow"}, overflow, v.exp_ovf);
    check({tag, "_idle"}, busy, 0);
    check_pops(tag, v.exp_pops, v.exp_last);
    $display("frame %s: pops=%0d ferr=%0b ovf=%0b", tag, got_q.size(), frame_err, overflow);
  endtask

  initial begin
    //           len0 len1 len2 lines early hold pops last ferr ovf
    tbl[0] = '{4, 4, 4, 3, 1'b0, 1'b0, 12, 12, 1'b0, 1'b0}; // normal
    tbl[1] = '{4, 3, 4, 3, 1'b0, 1'b0, 11, 11, 1'b1, 1'b0}; // short line 2
    tbl[2] = '{4, 4, 0, 2, 1'b1, 1'b0,  8,  0, 1'b1, 1'b0}; // early vsync
    tbl[3] = '{4, 4, 4, 3, 1'b0, 1'b1,  8,  0, 1'b0, 1'b1}; // back-pressure

    RST = 1'b1;
    v_sync = 1'b0; h_sync = 1'b1; start = 1'b0; abort = 1'b0;
    pix_data = '0; pix_ready = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge p_clk);
    @(negedge p_clk);
    check("rst_cap_h_sync", cap_h_sync, 0);
    check("rst_cap_rst_n", cap_rst_n, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_last", o_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    #1;
    RST = 1'b0;
    h_sync = 1'b0;
    tick(); tick();
    $display("reset checked");

    run_frame("normal", tbl[0]);
    run_frame("short", tbl[1]);
    run_frame("early", tbl[2]);
    run_frame("hold", tbl[3]);

    // Gating in ARM, then start while busy must not clear frame_err.
    got_q.delete();
    done_cnt = 0;
    next_pix = 1;
    i_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    h_sync = 1'b1;
    pix_data = 16'h00AA;
    pix_ready = 1'b1;
    @(negedge p_clk);
    check("arm_gate_closed", cap_h_sync, 0);
    check("arm_ovf_cleared", overflow, 0);
    repeat (4) tick();
    pix_ready = 1'b0;
    h_sync = 1'b0;
    tick(); tick();
    @(negedge p_clk);
    check("arm_no_push", o_valid, 0);
    vsync_pulse();
    h_sync = 1'b1;
    @(negedge p_clk);
    check("cap_gate_open", cap_h_sync, 1);
    drive_line(2);
    @(negedge p_clk);
    check("gate_short_ferr", frame_err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge p_clk);
    check("busy_start_ferr_kept", frame_err, 1);
    check("busy_start_still_busy", busy, 1);
    drive_line(4);
    drive_line(4);
    wait_done();
    check("gate_done_once", done_cnt, 1);
    check_pops("gate", 10, 10);
    $display("gating sequence: pops=%0d", got_q.size());

    // Abort after five buffered pixels.
    got_q.delete();
    done_cnt = 0;
    next_pix = 1;
    i_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vsync_pulse();
    drive_line(4);
    h_sync = 1'b1;
    pix_ready = 1'b1;
    pix_data = PW'(next_pix);
    tick();
    pix_ready = 1'b0;
    tick();
    @(negedge p_clk);
    check("abort_pre_valid", o_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    h_sync = 1'b0;
    @(negedge p_clk);
    check("abort_busy", busy, 0);
    check("abort_o_valid", o_valid, 0);
    check("abort_cap_rst_n", cap_rst_n, 0);
    repeat (6) @(negedge p_clk);
    check("abort_no_done", done_cnt, 0);
    $display("abort sequence: busy=%0b o_valid=%0b", busy, o_valid);

    run_frame("after_abort", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
